// File: rtl/alu_result_stream.sv
// ============================================================================
// Module   : alu_result_stream
// Purpose  : Result capture FIFO for the ALU sweep. Entries are streamed out
//            tagged with the (function, operand) coordinates of their position.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_stream #(
  parameter int DEPTH        = 180,
  parameter int NUM_FUNC     = 18,
  parameter int OPS_PER_FUNC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       wr_en,
  input  logic [7:0] wr_o,
  input  logic       wr_zr,
  input  logic       wr_ng,
  output logic       wr_full,
  output logic       overflow,
  output logic [7:0] count,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_o,
  output logic       rd_zr,
  output logic       rd_ng,
  output logic [4:0] rd_func,
  output logic [3:0] rd_opnd,
  output logic       rd_last
);

  localparam int               PTR_W       = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] C_LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [7:0]       C_DEPTH     = 8'(DEPTH);
  localparam logic [4:0]       C_LAST_FUNC = 5'(NUM_FUNC - 1);
  localparam logic [3:0]       C_LAST_OPND = 4'(OPS_PER_FUNC - 1);

  logic [9:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [7:0]       r_count;
  logic [4:0]       r_func;
  logic [3:0]       r_opnd;
  logic             r_ovf;

  logic             w_full;
  logic             w_valid;
  logic             w_accept;
  logic             w_pop;
  logic             w_drop;
  logic [9:0]       w_head;

  assign w_full   = (r_count == C_DEPTH);
  assign w_valid  = (r_count != 8'd0);
  assign w_accept = wr_en && !w_full && !clear;
  assign w_drop   = wr_en &&  w_full && !clear;
  assign w_pop    = w_valid && rd_ready && !clear;
  assign w_head   = r_mem[r_rp];

  // Storage carries no reset; only slots behind valid pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wp] <= {wr_zr, wr_ng, wr_o};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= 8'd0;
      r_func  <= 5'd0;
      r_opnd  <= 4'd0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= 8'd0;
      r_func  <= 5'd0;
      r_opnd  <= 4'd0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wp <= (r_wp == C_LAST_PTR) ? '0 : r_wp + PTR_W'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      if (w_pop) begin
        r_rp <= (r_rp == C_LAST_PTR) ? '0 : r_rp + PTR_W'(1);
        // Index walks operand-minor, wrapping to (0,0) after the last function.
        if (r_opnd == C_LAST_OPND) begin
          r_opnd <= 4'd0;
          r_func <= (r_func == C_LAST_FUNC) ? 5'd0 : r_func + 5'd1;
        end else begin
          r_opnd <= r_opnd + 4'd1;
        end
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 8'd1;
        2'b01:   r_count <= r_count - 8'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign wr_full  = w_full;
  assign overflow = r_ovf;
  assign count    = r_count;
  assign rd_valid = w_valid;
  assign rd_o     = w_valid ? w_head[7:0] : 8'd0;
  assign rd_ng    = w_valid ? w_head[8]   : 1'b0;
  assign rd_zr    = w_valid ? w_head[9]   : 1'b0;
  assign rd_func  = r_func;
  assign rd_opnd  = r_opnd;
  assign rd_last  = w_valid && (r_func == C_LAST_FUNC) && (r_opnd == C_LAST_OPND);

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stream.sv
// ============================================================================
// Module   : tb_alu_result_stream
// Purpose  : Self-checking bench for alu_result_stream against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_stream;

  localparam int DEPTH = 180;
  localparam int NUM_FUNC = 18;
  localparam int OPS_PER_FUNC = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_o = 8'd0;
  logic       wr_zr = 1'b0;
  logic       wr_ng = 1'b0;
  logic       rd_ready = 1'b0;
  logic       wr_full, overflow, rd_valid, rd_zr, rd_ng, rd_last;
  logic [7:0] count, rd_o;
  logic [4:0] rd_func;
  logic [3:0] rd_opnd;

  int ntests = 0;
  int nfail  = 0;

  alu_result_stream #(
    .DEPTH(DEPTH), .NUM_FUNC(NUM_FUNC), .OPS_PER_FUNC(OPS_PER_FUNC)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .wr_en(wr_en), .wr_o(wr_o), .wr_zr(wr_zr), .wr_ng(wr_ng),
    .wr_full(wr_full), .overflow(overflow), .count(count),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_o(rd_o), .rd_zr(rd_zr), .rd_ng(rd_ng),
    .rd_func(rd_func), .rd_opnd(rd_opnd), .rd_last(rd_last)
  );

  always #5 clk = ~clk;

  // Model: a queue of {zr, ng, o} plus the total number of pops since flush.
  logic [9:0] q[$];
  int         npop = 0;
  bit         ovf  = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset || clear) begin
      q.delete();
      npop = 0;
      ovf  = 1'b0;
    end else begin
      bit full_now, valid_now;
      full_now  = (q.size() == DEPTH);
      valid_now = (q.size() != 0);
      if (wr_en && full_now) ovf = 1'b1;
      if (valid_now && rd_ready) begin
        void'(q.pop_front());
        npop = (npop + 1) % DEPTH;
      end
      if (wr_en && !full_now) q.push_back({wr_zr, wr_ng, wr_o});
    end
  end

  function automatic logic [30:0] model_vec();
    int         sz;
    logic       v;
    logic [9:0] h;
    sz = q.size();
    v  = (sz != 0);
    h  = 10'd0;
    if (v) h = q[0];
    return {sz == DEPTH, ovf, 8'(sz), v, h[7:0], h[9], h[8],
            5'(npop / OPS_PER_FUNC), 4'(npop % OPS_PER_FUNC), v && (npop == DEPTH - 1)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cycle", {1'b0, wr_full, overflow, count, rd_valid, rd_o, rd_zr, rd_ng,
                  rd_func, rd_opnd, rd_last}, {1'b0, model_vec()});
  end

  // Applies inputs across one rising edge and returns at the following falling edge.
  task automatic drive(input logic w, input logic [7:0] o, input logic zr, input logic ng,
                       input logic rdy, input logic clr);
    wr_en = w; wr_o = o; wr_zr = zr; wr_ng = ng; rd_ready = rdy; clear = clr;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 8'(i), 1'(i % 2), 1'((i / 2) % 2), 1'b0, 1'b0);
  endtask

  task automatic pops(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flags", {26'd0, wr_full, overflow, rd_valid, rd_last, rd_zr, rd_ng}, 32'd0);
    chk("rst_index", {23'd0, rd_func, rd_opnd}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Basic write and read
    drive(1'b1, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("basic_valid1", 32'(rd_valid), 32'd1);
    drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("basic_count3", 32'(count), 32'd3);
    chk("basic_head0", {22'd0, rd_zr, rd_ng, rd_o}, 32'h03F);
    chk("basic_idx0", {23'd0, rd_func, rd_opnd}, 32'h000);
    pops(1);
    chk("basic_head1", {22'd0, rd_zr, rd_ng, rd_o}, 32'h200);
    chk("basic_idx1", {23'd0, rd_func, rd_opnd}, 32'h001);
    pops(1);
    chk("basic_head2", {22'd0, rd_zr, rd_ng, rd_o}, 32'h180);
    chk("basic_idx2", {23'd0, rd_func, rd_opnd}, 32'h002);
    pops(1);
    chk("basic_empty", 32'(rd_valid), 32'd0);

    // Overflow
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    fill(180);
    chk("ovf_full", 32'(wr_full), 32'd1);
    chk("ovf_count180", 32'(count), 32'd180);
    chk("ovf_not_yet", 32'(overflow), 32'd0);
    drive(1'b1, 8'd180, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count_held", 32'(count), 32'd180);

    // Sweep decode with continuous ready
    for (int i = 0; i < 180; i++) begin
      if (i == 10) chk("sweep_e10", {23'd0, rd_func, rd_opnd}, {23'd0, 5'd1, 4'd0});
      if (i == 179) begin
        chk("sweep_e179_o", 32'(rd_o), 32'd179);
        chk("sweep_e179_idx", {23'd0, rd_func, rd_opnd}, {23'd0, 5'd17, 4'd9});
        chk("sweep_e179_last", 32'(rd_last), 32'd1);
      end
      drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("sweep_count0", 32'(count), 32'd0);
    chk("sweep_wrap", {23'd0, rd_func, rd_opnd}, 32'd0);

    // Simultaneous write and pop
    fill(5);
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("simul_count5", 32'(count), 32'd5);
    pops(4);
    chk("simul_count1", 32'(count), 32'd1);
    drive(1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("simul_valid", 32'(rd_valid), 32'd1);
    chk("simul_head", {22'd0, rd_zr, rd_ng, rd_o}, 32'h1A5);
    chk("simul_count", 32'(count), 32'd1);

    // Clear priority over write and pop
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    fill(181);
    pops(173);
    chk("clr_pre_count", 32'(count), 32'd7);
    chk("clr_pre_ovf", 32'(overflow), 32'd1);
    drive(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_valid", 32'(rd_valid), 32'd0);
    chk("clr_index", {23'd0, rd_func, rd_opnd}, 32'd0);
    idle();
    chk("clr_not_stored", 32'(rd_valid), 32'd0);

    // Randomised traffic alternating write-heavy and read-heavy phases
    for (int c = 0; c < 3000; c++) begin
      bit wheavy;
      wheavy = ((c / 250) % 2) == 0;
      drive(1'($urandom_range(0, 99) < (wheavy ? 95 : 20)), 8'($urandom),
            1'($urandom), 1'($urandom),
            1'($urandom_range(0, 99) < (wheavy ? 15 : 90)),
            1'($urandom_range(0, 399) == 0));
    end

    // Asynchronous reset mid-stream
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    fill(50);
    idle();
    chk("arst_pre_count", 32'(count), 32'd50);
    #2 reset = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_flags", {29'd0, rd_valid, wr_full, rd_last}, 32'd0);
    chk("arst_index", {23'd0, rd_func, rd_opnd}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("arst_wr_head", {22'd0, rd_zr, rd_ng, rd_o}, 32'h25A);
    chk("arst_wr_idx", {23'd0, rd_func, rd_opnd}, 32'd0);
    chk("arst_wr_count", 32'(count), 32'd1);
    idle();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_result_stream.md
# alu_result_stream

Result capture and readout buffer for the 8-bit ALU characterisation flow. It accepts one ALU result per cycle (o, zr, ng) from the stimulus/capture side. It holds up to 180 entries, the full sweep of 18 function codes × 10 operand pairs. It streams the entries back out through a valid/ready port, and each entry is tagged with the function-code index and operand-pair index recovered from its sequence position. It is the read end of the sweep: a decoder from the linear result index back to (function, operand) coordinates.

## Interface
- DEPTH, 180, number of storage entries; must equal NUM_FUNC*OPS_PER_FUNC
- NUM_FUNC, 18, function codes per sweep; rd_func range 0..NUM_FUNC-1
- OPS_PER_FUNC, 10, operand pairs per function code; rd_opnd range 0..OPS_PER_FUNC-1
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- clear  input  1  synchronous flush; priority over wr_en and pop
- wr_en  input  1  write request for one result entry
- wr_o  input  8  ALU output o
- wr_zr  input  1  ALU zr flag
- wr_ng  input  1  ALU ng flag
- wr_full  output  1  high when count == DEPTH
- overflow  output  1  sticky; set when a write is dropped
- count  output  8  entries held, 0..DEPTH
- rd_valid  output  1  high when count != 0
- rd_ready  input  1  consumer accepts the head entry
- rd_o  output  8  head entry o; 0 when rd_valid low
- rd_zr  output  1  head entry zr; 0 when rd_valid low
- rd_ng  output  1  head entry ng; 0 when rd_valid low
- rd_func  output  5  function index of the head entry
- rd_opnd  output  4  operand index of the head entry
- rd_last  output  1  high when rd_valid is high and the head is (NUM_FUNC-1, OPS_PER_FUNC-1)

## Operation
- Storage: DEPTH × 10-bit array of {zr, ng, o}. Contents are not reset.
- Write pointer wp and read pointer rp each run 0..DEPTH-1. After DEPTH-1 they wrap to 0.
- Write accept: wr_en && !wr_full && !clear. On accept, store at wp, then wp++.
- Write when full: the entry is dropped, overflow <= 1, and wp/count are unchanged. This holds even if a pop occurs in the same cycle; full blocks the write regardless.
- Pop: rd_valid && rd_ready && !clear. On pop, rp++ and the read index advances.
- count: +1 on accept only, -1 on pop only. It is unchanged on accept+pop together, and unchanged on a dropped write.
- Read index (rd_func, rd_opnd) advances one step per pop:
  - rd_opnd++.
  - When rd_opnd == OPS_PER_FUNC-1, rd_opnd <= 0 and rd_func++.
  - When rd_func == NUM_FUNC-1 and rd_opnd == OPS_PER_FUNC-1, both go to 0.
- rd_o/rd_zr/rd_ng are a show-ahead read of storage[rp], forced to 0 while rd_valid is low.
- rd_last = rd_valid && rd_func == NUM_FUNC-1 && rd_opnd == OPS_PER_FUNC-1.
- clear: the next edge sets wp, rp, count, rd_func, rd_opnd and overflow to 0. Concurrent wr_en and pop are ignored.
- Handshake: the consumer may hold rd_ready high continuously. The head data stays stable while rd_valid is high and rd_ready is low.

## Timing
- Reset (asynchronous assert): count=0, wr_full=0, overflow=0, rd_valid=0, rd_o=0, rd_zr=0, rd_ng=0, rd_func=0, rd_opnd=0, rd_last=0. Release is synchronous to the next clk edge.
- Write to read latency: an entry accepted at edge N is visible at the head with rd_valid=1 after edge N, if the buffer was empty.
- Pop takes effect at the edge. The next head and index are visible after that same edge.
- Throughput: one write and one pop per cycle, sustained.
- Empty with wr_en: rd_valid rises after the edge. There is no same-cycle bypass.
- Count 1 with pop and write together: rd_valid stays high, and the head becomes the new entry.
- wr_full and count are registered outputs derived from count only. They are not combinational from wr_en.
- Reset mid-operation: all outputs drop asynchronously to their reset values. The pointers restart at 0 and the old data is abandoned.

## Test plan
- Basic write and read:
  - Stimulus: after reset, write {o=0x3F,zr=0,ng=0}, {0x00,1,0}, {0x80,0,1} with rd_ready=0.
  - Response: rd_valid=1 one edge after the first write and count=3. Then, with rd_ready=1, three pops return those entries in order with rd_func=0 and rd_opnd=0,1,2, and rd_valid=0 after the third pop.
- Overflow:
  - Stimulus: write 181 entries (o=index mod 256) with rd_ready=0.
  - Response: wr_full=1 and count=180 after the 180th write. The 181st write is dropped and overflow=1, with count still 180.
- Sweep decode:
  - Stimulus: drain all 180 entries.
  - Response: entry 10 shows rd_func=1, rd_opnd=0. Entry 179 shows o=179, rd_func=17, rd_opnd=9, rd_last=1. After the final pop, count=0 and the index wraps to rd_func=0, rd_opnd=0.
- Simultaneous operations:
  - Stimulus: at count=5, accept a write and a pop in the same cycle. Then, at count=1, do a write and a pop together.
  - Response: count stays 5 in the first case. In the second, rd_valid stays 1 and the head shows the new entry.
- Clear priority:
  - Stimulus: at count=7 with overflow=1, assert clear together with wr_en and a pop.
  - Response: next cycle count=0, overflow=0, rd_valid=0, rd_func=0, rd_opnd=0. The written entry is not stored.
- Async reset mid-stream:
  - Stimulus: at count=50, assert reset between clock edges.
  - Response: rd_valid, wr_full, count and the index all read 0 before the next edge. A subsequent write reads back at rd_func=0, rd_opnd=0.
